om_write_control: RTL
=====================

Name: om_write_control

Overview:
- Writer side of the output-memory (OM) handshake for the face-detection pipeline.
- Accepts a raster stream of per-position classifier results (80x60 = 4800 words per frame) and writes them into OM at addresses 0..4799.
- After the last word, pulses the run request that starts the window-sum/MV controller, then holds off new frames until that controller reports output ready.
- Prevents OM from being overwritten while the MV controller is reading it.

Parameters:
- FRAME_SIZE, 4800, words per frame; last address = FRAME_SIZE-1.
- ADDR_W, 13, OM address width.
- DATA_W, 8, OM data width.

Ports:
- iClk  in  1  system clock.
- iReset_n  in  1  synchronous active-low reset.
- iValid  in  1  input beat valid.
- iSof  in  1  start of frame; qualifies the first beat of a frame.
- iData  in  DATA_W  result word.
- iMV_done  in  1  single-cycle pulse from the MV controller's output-ready.
- oReady  out  1  block accepts a beat this cycle.
- oWr_OM  out  1  OM write enable.
- oAddr_OM  out  ADDR_W  OM write address.
- oData_OM  out  DATA_W  OM write data.
- oRun_MV  out  1  single-cycle start pulse to the MV controller.
- oBusy  out  1  a frame is loaded or being processed; OM is owned by the reader.
- oSync_err  out  1  single-cycle pulse on a protocol violation.
- oFrame_cnt  out  8  completed-frame count; wraps 255 -> 0.

Behaviour:
- Reset: sampled on posedge iClk when iReset_n=0. All outputs 0, state IDLE, address counter 0. Reset mid-frame abandons the frame with no pulse on oRun_MV. oReady rises the first cycle after reset release.
- Accept condition: iValid & oReady. Every accepted beat produces a write with 1-cycle latency: oWr_OM=1, oAddr_OM = current address, oData_OM = iData, all registered. Otherwise oWr_OM=0; oAddr_OM and oData_OM hold their previous values.
- Address counter: ADDR_W bits, increments by 1 per accepted beat in FILL. It never exceeds FRAME_SIZE-1.
- States:
  - IDLE: oReady=1, oBusy=0. An accepted beat with iSof=1 writes address 0, sets the counter to 1 and goes to FILL. An accepted beat with iSof=0 is dropped (no write) and pulses oSync_err.
  - FILL: oReady=1, oBusy=0. An accepted beat with iSof=0 writes the counter value and increments. An accepted beat with iSof=1 pulses oSync_err, writes address 0, sets the counter to 1 and stays in FILL (resync). An accepted beat at address FRAME_SIZE-1 is written, then the block goes to RUN; oReady=0 from the next cycle.
  - RUN: one cycle. oRun_MV=1, oBusy=1, oFrame_cnt+1, then WAIT.
  - WAIT: oReady=0, oBusy=1. Stays until iMV_done=1, then IDLE; oReady=1 the following cycle.
- iMV_done outside WAIT is ignored. iValid while oReady=0 is not accepted and is not an error; the source must hold the beat.
- iSof without iValid has no effect.
- Last-beat timing: the write to FRAME_SIZE-1 appears on oWr_OM in the same cycle oRun_MV=1. OM registers the write that edge, before the reader's first address.
- iMV_done arriving in the same cycle as RUN is not seen; the reader cannot finish in 0 cycles.

Test Plan:
- Reset, then 4800 consecutive beats with iSof on beat 0 and data = addr[7:0] -> oWr_OM on 4800 cycles, addresses 0..4799 in order, oRun_MV single pulse coincident with the addr 4799 write, oFrame_cnt=1, oReady=0.
- In WAIT, drive iValid=1 for 100 cycles, then pulse iMV_done -> no writes during WAIT; oReady=1 one cycle after iMV_done; next frame starts at addr 0.
- Beats with iSof=0 in IDLE (3 beats) -> 3 oSync_err pulses, no writes; the following iSof beat writes addr 0.
- Mid-frame resync: iSof at beat 1000 -> oSync_err pulse, that beat written at addr 0; oRun_MV fires only after 4800 further beats.
- Gapped input: iValid toggling 1/0 over a full frame -> addresses still contiguous 0..4799; exactly one oRun_MV pulse.
- iReset_n=0 for 1 cycle at addr 2500 -> all outputs 0, no oRun_MV; a fresh frame completes normally. Run 256 frames -> oFrame_cnt wraps to 0.

Source files
------------

// File: rtl/om_write_control.sv
// ---------------------------------------------------------------------------
// om_write_control
//
// Writer side of the output-memory (OM) handshake for the face-detection
// pipeline. A raster stream of per-position classifier results is written
// into OM at addresses 0..FRAME_SIZE-1. After the last word the block pulses
// oRun_MV to start the window-sum/MV controller. It then refuses new beats
// until that controller reports output ready on iMV_done, so OM is never
// overwritten while it is being read.
//
// Handshake: a beat transfers on a rising edge where iValid and oReady are
// both 1. While oReady is 0 the source must hold the beat; the block neither
// accepts it nor flags it. iSof only has meaning on a transferred beat.
//
// Ports
//   iClk        system clock
//   iReset_n    synchronous active-low reset
//   iValid      input beat valid
//   iSof        start of frame, qualifies the first beat of a frame
//   iData       result word
//   iMV_done    single-cycle output-ready pulse from the MV controller
//   oReady      block accepts a beat this cycle
//   oWr_OM      OM write enable (registered, 1-cycle latency)
//   oAddr_OM    OM write address (holds its value when no write)
//   oData_OM    OM write data (holds its value when no write)
//   oRun_MV     single-cycle start pulse to the MV controller
//   oBusy       frame loaded or being processed; OM owned by the reader
//   oSync_err   single-cycle pulse on a protocol violation
//   oFrame_cnt  completed-frame count, wraps 255 -> 0
// ---------------------------------------------------------------------------
module om_write_control #(
    parameter int FRAME_SIZE = 4800,
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8
) (
    input  logic              iClk,
    input  logic              iReset_n,
    input  logic              iValid,
    input  logic              iSof,
    input  logic [DATA_W-1:0] iData,
    input  logic              iMV_done,
    output logic              oReady,
    output logic              oWr_OM,
    output logic [ADDR_W-1:0] oAddr_OM,
    output logic [DATA_W-1:0] oData_OM,
    output logic              oRun_MV,
    output logic              oBusy,
    output logic              oSync_err,
    output logic [7:0]        oFrame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        WAIT = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_SIZE - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t            state;
    logic [ADDR_W-1:0] addr_cnt;
    logic              accept;

    assign accept = iValid & oReady;

    // All outputs are registered. oRun_MV, oBusy and the frame count are set
    // on the same edge that writes the last address, so the final OM write
    // and the run pulse appear together in the RUN cycle.
    always_ff @(posedge iClk) begin
        if (!iReset_n) begin
            state      <= IDLE;
            addr_cnt   <= '0;
            oReady     <= 1'b0;
            oWr_OM     <= 1'b0;
            oAddr_OM   <= '0;
            oData_OM   <= '0;
            oRun_MV    <= 1'b0;
            oBusy      <= 1'b0;
            oSync_err  <= 1'b0;
            oFrame_cnt <= '0;
        end else begin
            oWr_OM    <= 1'b0;
            oRun_MV   <= 1'b0;
            oSync_err <= 1'b0;

            case (state)
                IDLE: begin
                    // oReady comes up one cycle after reset release.
                    oReady <= 1'b1;
                    if (accept) begin
                        if (iSof) begin
                            oWr_OM   <= 1'b1;
                            oAddr_OM <= '0;
                            oData_OM <= iData;
                            addr_cnt <= ADDR_ONE;
                            state    <= FILL;
                        end else begin
                            // Beat outside a frame: dropped.
                            oSync_err <= 1'b1;
                        end
                    end
                end

                FILL: begin
                    if (accept) begin
                        oWr_OM   <= 1'b1;
                        oData_OM <= iData;
                        if (iSof) begin
                            // Resync: restart the frame with this beat.
                            oSync_err <= 1'b1;
                            oAddr_OM  <= '0;
                            addr_cnt  <= ADDR_ONE;
                        end else begin
                            oAddr_OM <= addr_cnt;
                            if (addr_cnt == LAST_ADDR) begin
                                addr_cnt   <= '0;
                                oReady     <= 1'b0;
                                oRun_MV    <= 1'b1;
                                oBusy      <= 1'b1;
                                oFrame_cnt <= oFrame_cnt + 8'd1;
                                state      <= RUN;
                            end else begin
                                addr_cnt <= addr_cnt + ADDR_ONE;
                            end
                        end
                    end
                end

                // iMV_done is not looked at here: the reader cannot finish
                // in the same cycle it is started.
                RUN: state <= WAIT;

                WAIT: begin
                    if (iMV_done) begin
                        oReady <= 1'b1;
                        oBusy  <= 1'b0;
                        state  <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
